// File: rtl/plru_way_allocator.sv
// Per-set way allocator: valid tracking, victim choice and refill handshake
// in front of the set's pseudo-LRU tracker.
module plru_way_allocator #(
  parameter int WAYS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hit_vld,
  input  logic [2:0]      i_hit_way,
  output logic            o_hit_rdy,
  output logic            o_hit_err,
  input  logic            i_inv_vld,
  input  logic [2:0]      i_inv_way,
  input  logic            i_miss_req,
  output logic            o_miss_ack,
  output logic            o_fill_req,
  output logic [2:0]      o_fill_way,
  output logic            o_fill_evict,
  input  logic            i_fill_done,
  output logic            o_alloc_done,
  output logic [2:0]      o_alloc_way,
  output logic            o_acc_en,
  output logic [2:0]      o_acc_idx,
  input  logic [2:0]      i_lru_idx,
  output logic [WAYS-1:0] o_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          r_state;
  logic [WAYS-1:0] r_valid;
  logic [2:0]      r_fill_way;
  logic            r_fill_evict;

  logic            w_idle;
  logic            w_commit;
  logic            w_accept;
  logic            w_hit_ok;
  logic            w_any_inv;
  logic [2:0]      w_low_inv;
  logic [2:0]      w_victim;
  logic            w_inv_ok;
  logic [WAYS-1:0] w_valid_nxt;

  assign w_idle   = (r_state == IDLE);
  assign w_commit = (r_state == COMMIT);
  assign w_accept = w_idle & i_miss_req;

  assign o_hit_rdy  = ~w_commit;
  assign w_hit_ok   = i_hit_vld & o_hit_rdy & r_valid[i_hit_way];
  assign o_hit_err  = i_hit_vld & o_hit_rdy & ~r_valid[i_hit_way];

  assign o_miss_ack   = w_idle;
  assign o_fill_req   = (r_state == FILL);
  assign o_fill_way   = r_fill_way;
  assign o_fill_evict = r_fill_evict;
  assign o_alloc_done = w_commit;
  assign o_alloc_way  = r_fill_way;
  assign o_valid      = r_valid;

  // COMMIT blocks the hit port, so the two sources never collide
  assign o_acc_en  = w_commit | w_hit_ok;
  assign o_acc_idx = w_commit ? r_fill_way :
                     (w_hit_ok ? i_hit_way : 3'd0);

  always_comb begin
    w_any_inv = 1'b0;
    w_low_inv = 3'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_any_inv = 1'b1;
        w_low_inv = i[2:0];
      end
    end
  end

  assign w_victim = w_any_inv ? w_low_inv : i_lru_idx;

  // an in-flight allocation is shielded from invalidates of its own way
  assign w_inv_ok = i_inv_vld &
                    ~(~w_idle & (i_inv_way == r_fill_way));

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_inv_ok)
      w_valid_nxt[i_inv_way] = 1'b0;
    if (w_accept)
      w_valid_nxt[w_victim] = 1'b0;
    if (w_commit)
      w_valid_nxt[r_fill_way] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_fill_way   <= 3'd0;
      r_fill_evict <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      unique case (r_state)
        IDLE: begin
          if (i_miss_req) begin
            r_state      <= FILL;
            r_fill_way   <= w_victim;
            r_fill_evict <= r_valid[w_victim];
          end
        end
        FILL: begin
          if (i_fill_done)
            r_state <= COMMIT;
        end
        COMMIT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_way_allocator.sv
// Directed bench for plru_way_allocator with hand-computed expectations.
`timescale 1ns/1ps
module tb_plru_way_allocator;

  logic       clk;
  logic       rst_n;
  logic       hit_vld;
  logic [2:0] hit_way;
  logic       hit_rdy;
  logic       hit_err;
  logic       inv_vld;
  logic [2:0] inv_way;
  logic       miss_req;
  logic       miss_ack;
  logic       fill_req;
  logic [2:0] fill_way;
  logic       fill_evict;
  logic       fill_done;
  logic       alloc_done;
  logic [2:0] alloc_way;
  logic       acc_en;
  logic [2:0] acc_idx;
  logic [2:0] lru_idx;
  logic [7:0] valid;

  int n_chk;
  int n_err;

  plru_way_allocator #(.WAYS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_hit_vld    (hit_vld),
    .i_hit_way    (hit_way),
    .o_hit_rdy    (hit_rdy),
    .o_hit_err    (hit_err),
    .i_inv_vld    (inv_vld),
    .i_inv_way    (inv_way),
    .i_miss_req   (miss_req),
    .o_miss_ack   (miss_ack),
    .o_fill_req   (fill_req),
    .o_fill_way   (fill_way),
    .o_fill_evict (fill_evict),
    .i_fill_done  (fill_done),
    .o_alloc_done (alloc_done),
    .o_alloc_way  (alloc_way),
    .o_acc_en     (acc_en),
    .o_acc_idx    (acc_idx),
    .i_lru_idx    (lru_idx),
    .o_valid      (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // accept, one FILL cycle, COMMIT, back to IDLE
  task automatic alloc(input logic [2:0] lru,
                       input logic [2:0] e_way,
                       input logic       e_evict,
                       input logic [7:0] e_vfill,
                       input logic       hit_in_commit);
    @(negedge clk);
    miss_req = 1'b1;
    lru_idx  = lru;
    #1 chk("ack_idle", miss_ack, 1);
    @(negedge clk);
    miss_req = 1'b0;
    chk("fill_req", fill_req, 1);
    chk("fill_way", fill_way, e_way);
    chk("fill_evict", fill_evict, e_evict);
    chk("valid_fill", valid, e_vfill);
    chk("ack_fill", miss_ack, 0);
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    if (hit_in_commit) begin
      hit_vld = 1'b1;
      hit_way = 3'd1;
    end
    #1;
    chk("alloc_done", alloc_done, 1);
    chk("alloc_way", alloc_way, e_way);
    chk("acc_en_cm", acc_en, 1);
    chk("acc_idx_cm", acc_idx, e_way);
    chk("hit_rdy_cm", hit_rdy, 0);
    chk("hit_err_cm", hit_err, 0);
    chk("ack_cm", miss_ack, 0);
    @(negedge clk);
    hit_vld = 1'b0;
    #1;
    chk("ack_back", miss_ack, 1);
    chk("alloc_off", alloc_done, 0);
    chk("acc_en_off", acc_en, 0);
    chk("valid_set", valid[e_way], 1);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    hit_vld   = 1'b0;
    hit_way   = 3'd0;
    inv_vld   = 1'b0;
    inv_way   = 3'd0;
    miss_req  = 1'b0;
    fill_done = 1'b0;
    lru_idx   = 3'd0;
    #12;
    chk("rst_ack", miss_ack, 1);
    chk("rst_hit_rdy", hit_rdy, 1);
    chk("rst_fill_req", fill_req, 0);
    chk("rst_alloc", alloc_done, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_hit_err", hit_err, 0);
    chk("rst_fill_way", fill_way, 0);
    chk("rst_alloc_way", alloc_way, 0);
    chk("rst_acc_idx", acc_idx, 0);
    chk("rst_evict", fill_evict, 0);
    chk("rst_valid", valid, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // cold fill: lowest invalid way wins over the PLRU hint
    for (int i = 0; i < 8; i++)
      alloc(3'd7, i[2:0], 1'b0, 8'((1 << i) - 1), 1'b0);
    chk("cold_valid", valid, 8'hFF);

    // full set: PLRU victim
    alloc(3'd5, 3'd5, 1'b1, 8'hDF, 1'b0);
    chk("plru_valid", valid, 8'hFF);

    // invalid-first
    @(negedge clk);
    inv_vld = 1'b1;
    inv_way = 3'd6;
    #1 chk("inv_no_acc", acc_en, 0);
    @(negedge clk);
    inv_way = 3'd2;
    @(negedge clk);
    inv_vld = 1'b0;
    chk("inv_valid", valid, 8'hBB);
    alloc(3'd4, 3'd2, 1'b0, 8'hBB, 1'b0);
    chk("inv1_valid", valid, 8'hBF);
    alloc(3'd4, 3'd6, 1'b0, 8'hBF, 1'b0);
    chk("inv2_valid", valid, 8'hFF);

    // hits
    @(negedge clk);
    hit_vld = 1'b1;
    hit_way = 3'd3;
    #1;
    chk("hit_acc_en", acc_en, 1);
    chk("hit_acc_idx", acc_idx, 3);
    chk("hit_err0", hit_err, 0);
    @(negedge clk);
    hit_vld = 1'b0;
    inv_vld = 1'b1;
    inv_way = 3'd3;
    @(negedge clk);
    inv_vld = 1'b0;
    hit_vld = 1'b1;
    #1;
    chk("hinv_acc_en", acc_en, 0);
    chk("hinv_err", hit_err, 1);
    chk("hinv_valid", valid, 8'hF7);
    @(negedge clk);
    hit_vld = 1'b0;
    // hit blocked while COMMIT presents the fill way
    alloc(3'd0, 3'd3, 1'b0, 8'hF7, 1'b1);
    chk("hcm_valid", valid, 8'hFF);

    // stalled fill with invalidate of the fill way
    @(negedge clk);
    miss_req = 1'b1;
    lru_idx  = 3'd1;
    @(negedge clk);
    miss_req = 1'b0;
    chk("st_way", fill_way, 1);
    chk("st_evict", fill_evict, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        inv_vld = 1'b1;
        inv_way = 3'd1;
      end
      if (i == 5) begin
        inv_vld = 1'b0;
        chk("st_inv_ign", valid, 8'hFD);
      end
      chk("st_fill_req", fill_req, 1);
      chk("st_ack", miss_ack, 0);
      chk("st_way_hold", fill_way, 1);
      @(negedge clk);
    end
    chk("st_fill_req_end", fill_req, 1);
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    chk("st_commit", alloc_done, 1);
    chk("st_ack_cm", miss_ack, 0);
    @(negedge clk);
    chk("st_valid", valid, 8'hFF);
    chk("st_ack_back", miss_ack, 1);

    // reset mid-FILL
    @(negedge clk);
    miss_req = 1'b1;
    lru_idx  = 3'd0;
    @(negedge clk);
    miss_req = 1'b0;
    chk("rf_fill_req", fill_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_fill_req0", fill_req, 0);
    chk("rf_ack", miss_ack, 1);
    chk("rf_valid", valid, 8'h00);
    chk("rf_fill_way", fill_way, 0);
    chk("rf_evict", fill_evict, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    fill_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rf_no_alloc", alloc_done, 0);
      chk("rf_no_fill", fill_req, 0);
    end
    fill_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
